// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST master.
package mem_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP,
        ST_DONE
    } st_e;

    typedef enum logic [1:0] {
        P_WR0,
        P_RD0,
        P_WR1,
        P_RD1
    } pass_e;

    localparam logic [7:0] DEF_SEED = 8'hA5;

    // March data for a given pass and address; inverse passes flip every bit.
    // Computed at 32 bits, callers truncate to their data width.
    function automatic logic [31:0] exp_data(input pass_e p, input logic [31:0] seed,
                                             input logic [31:0] addr);
        logic [31:0] v;
        v = seed ^ addr;
        if (p == P_WR1 || p == P_RD1) begin
            v = ~v;
        end
        return v;
    endfunction

endpackage

// File: rtl/mem_bist_master_port.sv
// Request-port handshake engine: one valid/ready transfer at a time with a
// per-state wait counter that aborts on a stuck handshake.
module mem_req_port
    import mem_bist_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  last,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic                  ack,
    output logic [WIDTH-1:0]      rdata,
    output logic                  to,
    output logic                  fin,
    output logic                  busy,
    output logic                  mem_valid,
    output logic                  mem_wr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic                  mem_ready,
    input  logic [WIDTH-1:0]      mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    st_e           state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wait_exp;

    assign wait_exp = (cnt_q == CW'(TIMEOUT - 1));

    // Next state, completion/abort pulses and wait counter.
    always_comb begin
        state_d = state_q;
        ack     = 1'b0;
        to      = 1'b0;
        fin     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (req) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    ack     = 1'b1;
                    state_d = ST_GAP;
                end else if (wait_exp) begin
                    to      = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_GAP: begin
                if (!mem_ready) begin
                    if (last) begin
                        fin     = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else if (wait_exp) begin
                    to      = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields are gated by valid so the port idles at all-zero and
    // drops immediately when reset asserts.
    assign mem_valid = (state_q == ST_REQ);
    assign mem_wr_rd = mem_valid & wr;
    assign mem_addr  = mem_valid ? addr  : '0;
    assign mem_wdata = mem_valid ? wdata : '0;
    assign busy      = (state_q == ST_REQ) || (state_q == ST_GAP);
    assign rdata     = mem_rdata;

endmodule

// File: rtl/mem_bist_master.sv
// Four-pass march BIST master: sequences passes and addresses, compares read
// data and keeps the pass/fail status for the test controller.
module mem_bist_master
    import mem_bist_pkg::*;
#(
    parameter int                 WIDTH      = 8,
    parameter int                 DEPTH      = 256,
    parameter int                 ADDR_WIDTH = 8,
    parameter logic [WIDTH-1:0]   SEED       = WIDTH'(DEF_SEED),
    parameter int                 TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    mem_valid,
    output logic                    mem_wr_rd,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]        mem_wdata,
    input  logic                    mem_ready,
    input  logic [WIDTH-1:0]        mem_rdata,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ADDR_WIDTH+2:0]   err_cnt,
    output logic [ADDR_WIDTH-1:0]   first_err_addr,
    output logic                    timeout
);

    pass_e                 pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH+2:0] err_q, err_d;
    logic [ADDR_WIDTH-1:0] first_q, first_d;
    logic                  done_q, done_d;
    logic                  ok_q, ok_d;
    logic                  to_q, to_d;
    logic                  last_q, last_d;

    logic                  launch;
    logic                  wr;
    logic [WIDTH-1:0]      exp_w;
    logic                  ack, to, fin, port_busy;
    logic [WIDTH-1:0]      rdata;

    assign launch = start & ~port_busy;
    assign wr     = (pass_q == P_WR0) || (pass_q == P_WR1);
    assign exp_w  = WIDTH'(exp_data(pass_q, 32'(SEED), 32'(addr_q)));

    mem_req_port #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) u_port (
        .clk       (clk),
        .rst       (rst),
        .req       (launch),
        .last      (last_q),
        .wr        (wr),
        .addr      (addr_q),
        .wdata     (exp_w),
        .ack       (ack),
        .rdata     (rdata),
        .to        (to),
        .fin       (fin),
        .busy      (port_busy),
        .mem_valid (mem_valid),
        .mem_wr_rd (mem_wr_rd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    // Sequencing, compare and status next-state.
    always_comb begin
        pass_d  = pass_q;
        addr_d  = addr_q;
        err_d   = err_q;
        first_d = first_q;
        done_d  = done_q;
        ok_d    = ok_q;
        to_d    = to_q;
        last_d  = last_q;

        if (launch) begin
            pass_d  = P_WR0;
            addr_d  = '0;
            err_d   = '0;
            first_d = '0;
            done_d  = 1'b0;
            ok_d    = 1'b0;
            to_d    = 1'b0;
            last_d  = 1'b0;
        end

        if (ack) begin
            if (!wr && (rdata != exp_w)) begin
                if (err_q != '1) begin
                    err_d = err_q + 1'b1;
                end
                if (err_q == '0) begin
                    first_d = addr_q;
                end
            end
            // The final P3 transfer wraps both counters back to zero, so the
            // end of the run is remembered separately for the trailing gap.
            if (addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                addr_d = '0;
                pass_d = pass_e'(pass_q + 2'd1);
                if (pass_q == P_RD1) begin
                    last_d = 1'b1;
                end
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end

        if (fin) begin
            done_d = 1'b1;
            ok_d   = (err_q == '0) && !to_q;
        end

        if (to) begin
            done_d = 1'b1;
            to_d   = 1'b1;
            ok_d   = 1'b0;
        end
    end

    // Sequencing and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q  <= P_WR0;
            addr_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            to_q    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            pass_q  <= pass_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            first_q <= first_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            to_q    <= to_d;
            last_q  <= last_d;
        end
    end

    assign busy           = port_busy;
    assign done           = done_q;
    assign pass           = ok_q;
    assign err_cnt        = err_q;
    assign first_err_addr = first_q;
    assign timeout        = to_q;

endmodule

// File: tb/tb_mem_bist_master.sv
// Directed self-checking bench for mem_bist_master with a behavioural RAM.
module tb_mem_bist_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mem_valid, mem_wr_rd;
    logic [7:0]  mem_addr, mem_wdata;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic        busy, done, pass, timeout;
    logic [10:0] err_cnt;
    logic [7:0]  first_err_addr;

    int n_cmp = 0;
    int n_bad = 0;

    // RAM model behaviour: 0 ideal, 1 bit0 stuck-at-0 at 0x10,
    // 2 returns inverted data, 3 never ready.
    int mode = 0;

    mem_bist_master #(
        .WIDTH      (8),
        .DEPTH      (256),
        .ADDR_WIDTH (8),
        .SEED       (8'hA5),
        .TIMEOUT    (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mem_valid      (mem_valid),
        .mem_wr_rd      (mem_wr_rd),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    // RAM with registered ready plus a request-trace scoreboard.
    logic [7:0] mem [256];
    logic       rdy_q;
    logic [7:0] rd_q;
    int         trace_n = 0;
    int         trace_bad = 0;
    logic [9:0] tk;
    logic [7:0] t_exp;

    assign mem_ready = rdy_q;
    assign mem_rdata = rd_q;
    assign tk        = trace_n[9:0];
    assign t_exp     = tk[9] ? ~(8'hA5 ^ tk[7:0]) : (8'hA5 ^ tk[7:0]);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q <= 1'b0;
            rd_q  <= 8'h00;
        end else begin
            rdy_q <= mem_valid && (mode != 3);
            if (start && !busy) begin
                trace_n <= 0;
            end
            if (mem_valid && !rdy_q && (mode != 3)) begin
                trace_n <= trace_n + 1;
                if (mem_addr != tk[7:0] || mem_wr_rd != !tk[8] ||
                    (mem_wr_rd && mem_wdata != t_exp)) begin
                    trace_bad <= trace_bad + 1;
                end
                if (mem_wr_rd) begin
                    mem[mem_addr] <= (mode == 1 && mem_addr == 8'h10) ?
                                     (mem_wdata & 8'hFE) : mem_wdata;
                end else begin
                    rd_q <= (mode == 2) ? ~mem[mem_addr] : mem[mem_addr];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start so it is sampled on the next rising edge, then check the
    // immediate effect of that edge.
    task automatic launch(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy_on_start"}, 64'(busy), 64'd1);
        chk({tag, "_done_cleared"}, 64'(done), 64'd0);
    endtask

    // Count rising edges after the start edge until done; -1 if the bound
    // expires. Optionally pulses start at a given cycle of the run.
    task automatic run_wait(input int poke, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 6000; i++) begin
            @(posedge clk);
            #1;
            start = (i == poke);
            if (done) begin
                cyc = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({mem_valid, mem_wr_rd, mem_addr, mem_wdata, busy, done,
                    pass, err_cnt, first_err_addr, timeout});
    endfunction

    int cyc;

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clean run.
        mode = 0;
        launch("clean");
        run_wait(0, cyc);
        chk("clean_cycles", 64'(cyc), 64'd4096);
        chk("clean_pass", 64'(pass), 64'd1);
        chk("clean_err", 64'(err_cnt), 64'd0);
        chk("clean_first", 64'(first_err_addr), 64'd0);
        chk("clean_timeout", 64'(timeout), 64'd0);
        chk("clean_busy_low", 64'(busy), 64'd0);
        chk("clean_trace_len", 64'(trace_n), 64'd1024);
        chk("clean_trace_bad", 64'(trace_bad), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("done_held", 64'({done, pass, mem_valid}), 64'b110);

        // Restart from DONE with a start pulse at cycle 100 that must be ignored.
        launch("ignore");
        run_wait(100, cyc);
        chk("ignore_cycles", 64'(cyc), 64'd4096);
        chk("ignore_pass", 64'(pass), 64'd1);
        chk("ignore_trace_len", 64'(trace_n), 64'd1024);

        // Stuck bit: only the P1 read at 0x10 fails (B5 reads back as B4).
        mode = 1;
        launch("stuck");
        run_wait(0, cyc);
        chk("stuck_cycles", 64'(cyc), 64'd4096);
        chk("stuck_err", 64'(err_cnt), 64'd1);
        chk("stuck_first", 64'(first_err_addr), 64'h10);
        chk("stuck_pass", 64'(pass), 64'd0);
        chk("stuck_timeout", 64'(timeout), 64'd0);

        // Every read inverted: 512 mismatches, first at address 0.
        mode = 2;
        launch("sat");
        run_wait(0, cyc);
        chk("sat_err", 64'(err_cnt), 64'd512);
        chk("sat_first", 64'(first_err_addr), 64'd0);
        chk("sat_pass", 64'(pass), 64'd0);

        // Handshake timeout with ready stuck low; start clears err_cnt first.
        mode = 3;
        launch("to");
        chk("to_err_cleared", 64'(err_cnt), 64'd0);
        run_wait(0, cyc);
        chk("to_cycles", 64'(cyc), 64'd16);
        chk("to_flag", 64'(timeout), 64'd1);
        chk("to_pass", 64'(pass), 64'd0);
        chk("to_valid_low", 64'(mem_valid), 64'd0);
        chk("to_busy_low", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("to_valid_stays_low", 64'(mem_valid), 64'd0);

        // Mid-run reset must clear every output before the next edge.
        mode = 0;
        launch("midrst");
        repeat (2000) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_valid) break;
        end
        chk("midrst_valid_before", 64'(mem_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        launch("after_rst");
        run_wait(0, cyc);
        chk("after_rst_cycles", 64'(cyc), 64'd4096);
        chk("after_rst_pass", 64'(pass), 64'd1);
        chk("after_rst_err", 64'(err_cnt), 64'd0);
        chk("after_rst_trace_bad", 64'(trace_bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bist_master.md
# mem_bist_master

Initiator-side test engine for the team's single-port RAM. On `start` it drives the RAM's `valid`/`ready` request port through a four-pass march: write pattern, read/compare, write inverse, read/compare. It then reports pass/fail, the error count, the first failing address and timeouts. It sits between the SoC test controller and the 256x8 RAM instance and holds the RAM port exclusively while busy.

## Interface
- `WIDTH`, 8, data width in bits.
- `DEPTH`, 256, number of addresses tested, 0..DEPTH-1.
- `ADDR_WIDTH`, 8, address width.
- `SEED`, 8'hA5, pattern seed.
- `TIMEOUT`, 16, maximum cycles spent waiting on any single `mem_ready` edge.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle launch pulse; ignored while `busy`.
- `mem_valid`  out  1  request valid to RAM.
- `mem_wr_rd`  out  1  1 = write, 0 = read.
- `mem_addr`  out  ADDR_WIDTH  request address.
- `mem_wdata`  out  WIDTH  write data.
- `mem_ready`  in  1  RAM ready, registered one cycle after `valid`.
- `mem_rdata`  in  WIDTH  RAM read data, valid while `mem_ready`=1 on reads.
- `busy`  out  1  test in progress.
- `done`  out  1  test finished; held until next `start` or reset.
- `pass`  out  1  qualified by `done`: 1 = zero mismatches and no timeout.
- `err_cnt`  out  ADDR_WIDTH+3  mismatch count, saturating at all-ones.
- `first_err_addr`  out  ADDR_WIDTH  address of first mismatch; 0 if none.
- `timeout`  out  1  qualified by `done`: aborted on handshake timeout.

## Operation
- **Reset values.** On reset, every output is 0 and the FSM is in IDLE. Assertion is asynchronous: `mem_valid` drops immediately, including mid-transfer.
- **FSM states.** IDLE, REQ, GAP, DONE.
  - IDLE/DONE, on `start`: clear `err_cnt`, `first_err_addr`, `timeout` and `done`; set pass=0, addr=0; go to REQ. `busy` is 1 in REQ and GAP only.
  - REQ: drive `mem_valid`=1 with stable `wr_rd`/`addr`/`wdata`. On a sampled `mem_ready`=1, the transfer completes: on reads, compare `mem_rdata` in that same cycle. Then go to GAP with `mem_valid`=0.
  - GAP: hold `mem_valid`=0 until `mem_ready`=0 is sampled. Then advance to the next transfer (REQ), or go to DONE after the last one.
- **Passes (2-bit counter).** Each pass sweeps addr 0→DEPTH-1.
  - P0: write `SEED^addr[WIDTH-1:0]`.
  - P1: read, expect `SEED^addr`.
  - P2: write `~(SEED^addr)`.
  - P3: read, expect `~(SEED^addr)`.
- **Address wrap.** At addr DEPTH-1 the address wraps to 0 and the pass increments. The last transfer is P3 at DEPTH-1.
- **Mismatch.** On `mem_rdata` != expected:
  - `err_cnt`+1, saturating.
  - If `err_cnt` was 0, latch `first_err_addr`=addr.
- **Timeout.** A per-state wait counter resets on state entry. If it reaches TIMEOUT in REQ or GAP:
  - `mem_valid`→0, `timeout`=1, go to DONE.
  - `pass`=0; `err_cnt` keeps its value.
- **DONE.** `done`=1, `pass`=(err_cnt==0 && !timeout).
- **`start` while busy.** Ignored with no side effects. `start` in DONE restarts the test.

## Timing
- **One transfer, against a RAM with 1-cycle registered ready.** Edges E0–E4:
  - E0: enter REQ, `mem_valid` rises.
  - E1: RAM executes and raises ready.
  - E2: engine samples ready, captures/compares rdata, drops valid.
  - E3: RAM drops ready.
  - E4: engine samples ready=0 and enters the next REQ.
  - Result: 4 cycles per transfer.
- **Full run.** 4·DEPTH transfers = 4096 cycles for default parameters. `done` rises 4096 cycles after the `start` edge, and `busy` falls on that same edge.
- **Flag timing.** `err_cnt` and `first_err_addr` update on the edge after the completing read. `done`, `pass` and `timeout` update on the DONE-entry edge.
- **Timeout abort.** With `mem_ready` stuck at 0, `done`=`timeout`=1 exactly TIMEOUT cycles after REQ entry.

## Structure
- **Package `mem_bist_pkg`.**
  - FSM state encoding (IDLE, REQ, GAP, DONE).
  - Pass encoding (P_WR0, P_RD0, P_WR1, P_RD1).
  - Default SEED.
  - Expected-data function `exp_data(pass, addr)`.
- **Sub-module `mem_req_port`.**
  - Owns the REQ/GAP handshake and timeout counter.
  - Inputs: `req`, `wr`, `addr`, `wdata`.
  - Outputs: `ack` pulse, captured `rdata`, `to` pulse, and drives `mem_*`.
- **Top level.** Holds the pass/address counters, compare logic and status registers.

## Test plan
- **Clean run.** Ideal RAM model; `start` → `done`=1 at +4096 cycles, `pass`=1, `err_cnt`=0, `first_err_addr`=0. Request trace is 256 writes of `A5^addr`, 256 reads, 256 writes of `~(A5^addr)`, 256 reads.
- **Stuck bit.** Model bit 0 stuck at 0 at addr 8'h10 → `err_cnt`=1, `first_err_addr`=8'h10, `pass`=0. Only the P1 read fails: A5^10=B5 reads as B4, while the P3 expectation 4A has bit 0 already 0.
- **Timeout.** `mem_ready` tied 0 → `done`=1, `timeout`=1, `pass`=0 at 16 cycles after REQ entry; `mem_valid`=0 afterwards.
- **Ignored start.** `start` pulsed at cycle 100 of a run → no restart; `done` still at +4096.
- **Mid-run reset.** `rst` asserted at cycle 2000 → all outputs 0 asynchronously, before the next edge. A later `start` runs clean to `pass`=1.
- **Saturation.** Model returning ~expected on all reads, with params WIDTH=8, DEPTH=256 → `err_cnt`=512, `first_err_addr`=0. A 9-address-bit variant instead saturates `err_cnt` at 2^12-1.
